// File: rtl/lives_hud_manager_if.sv
// lives_hud_manager_if: pixel position, game events and HUD pixel/status outputs
interface lives_hud_manager_if;
  logic [15:0] i_x;
  logic [15:0] i_y;
  logic i_v_sync;
  logic i_barrier_hit;
  logic i_extra_life;
  logic i_restart;
  logic [7:0] o_red;
  logic [7:0] o_green;
  logic [7:0] o_blue;
  logic o_sprite_hit;
  logic [2:0] o_lives;
  logic o_out_of_lives;
  logic o_invulnerable;
  modport master(output i_x, i_y, i_v_sync, i_barrier_hit, i_extra_life, i_restart,
                 input o_red, o_green, o_blue, o_sprite_hit, o_lives, o_out_of_lives, o_invulnerable);
  modport slave(input i_x, i_y, i_v_sync, i_barrier_hit, i_extra_life, i_restart,
                output o_red, o_green, o_blue, o_sprite_hit, o_lives, o_out_of_lives, o_invulnerable);
endinterface

// File: rtl/lives_hud_manager.sv
// lives_hud_manager: life count, hit invulnerability state machine and heart-row HUD renderer
module lives_hud_manager #(
  parameter int MAX_LIVES = 3,
  parameter int START_LIVES = 3,
  parameter int INVULN_FRAMES = 60,
  parameter int BLINK_SHIFT = 3,
  parameter int HUD_X = 80,
  parameter int HUD_Y = 20,
  parameter int SCALE_SHIFT = 3,
  parameter int ICON_SHIFT = 3
) (
  input logic i_clk,
  input logic i_reset,
  lives_hud_manager_if.slave bus
);
  typedef enum logic [1:0] {ALIVE, INVULN, GAME_OVER} state_t;
  state_t state, state_n;
  logic [2:0] lives, lives_n, lives_up;
  logic [7:0] cnt, cnt_n, frame;
  logic pv, ph, pe, vs_p, hit_p, xl_p;
  logic [15:0] dx, dy, cx, cy, icon, col;
  logic [4:0] row;
  logic in_reg, lit, full;
  assign vs_p = bus.i_v_sync & ~pv;
  assign hit_p = bus.i_barrier_hit & ~ph;
  assign xl_p = bus.i_extra_life & ~pe;
  assign lives_up = lives == 3'(MAX_LIVES) ? lives : lives + 3'd1;
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= ALIVE;
      lives <= 3'(START_LIVES);
      cnt <= '0;
      frame <= '0;
      {pv, ph, pe} <= '0;
    end else begin
      state <= state_n;
      lives <= lives_n;
      cnt <= cnt_n;
      frame <= frame + {7'd0, vs_p};
      {pv, ph, pe} <= {bus.i_v_sync, bus.i_barrier_hit, bus.i_extra_life};
    end
  end
  // a simultaneous extra life cancels the hit's decrement, so a last-life hit survives
  always_comb begin
    state_n = state;
    lives_n = (state != GAME_OVER && xl_p) ? lives_up : lives;
    cnt_n = cnt;
    case (state)
      ALIVE:
        if (hit_p) begin
          if (lives == 3'd1 && !xl_p) begin
            state_n = GAME_OVER;
            lives_n = '0;
          end else begin
            state_n = INVULN;
            lives_n = xl_p ? lives : lives - 3'd1;
            cnt_n = 8'(INVULN_FRAMES);
          end
        end
      INVULN:
        if (vs_p) begin
          cnt_n = cnt - 8'd1;
          state_n = cnt == 8'd1 ? ALIVE : INVULN;
        end
      default:
        if (bus.i_restart) begin
          state_n = ALIVE;
          lives_n = 3'(START_LIVES);
          cnt_n = '0;
        end
    endcase
  end
  always_comb begin
    bus.o_lives = lives;
    bus.o_out_of_lives = state == GAME_OVER;
    bus.o_invulnerable = state == INVULN;
  end
  // region test guards against i_x/i_y below the HUD origin wrapping into dx/dy
  always_comb begin
    dx = bus.i_x - 16'(HUD_X);
    dy = bus.i_y - 16'(HUD_Y);
    cx = dx >> SCALE_SHIFT;
    cy = dy >> SCALE_SHIFT;
    icon = cx >> ICON_SHIFT;
    col = cx & 16'((1 << ICON_SHIFT) - 1);
    in_reg = bus.i_x >= 16'(HUD_X) && bus.i_y >= 16'(HUD_Y) &&
             dx < 16'(MAX_LIVES << (ICON_SHIFT + SCALE_SHIFT)) && dy < 16'(5 << SCALE_SHIFT);
    row = cy == 16'd0 ? 5'b01010 : cy == 16'd3 ? 5'b01110 : cy == 16'd4 ? 5'b00100 : 5'b11111;
    lit = in_reg && col < 16'd5 && row[3'(16'd4 - col)] && !(state == INVULN && frame[BLINK_SHIFT]);
    full = icon < {13'd0, lives};
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      bus.o_sprite_hit <= 1'b0;
      bus.o_red <= '0;
      bus.o_green <= '0;
      bus.o_blue <= '0;
    end else begin
      bus.o_sprite_hit <= lit;
      bus.o_red <= lit ? (full ? 8'hff : 8'h20) : 8'h00;
      bus.o_green <= lit && !full ? 8'h20 : 8'h00;
      bus.o_blue <= lit && !full ? 8'h20 : 8'h00;
    end
  end
endmodule
